// File: rtl/hwt_bist_pkg.sv
// Shared types and the golden reference function for the gate-level BIST controller.
// golden_y is also used by the testbench scoreboard.
package hwt_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int VEC_W = 4;

  // vec = {A,B,C,D}; Y = D & ((A & B) | C)
  function automatic logic golden_y(input logic [VEC_W-1:0] vec);
    return vec[0] & ((vec[3] & vec[2]) | vec[1]);
  endfunction

endpackage

// File: rtl/hwt_bist_vecgen.sv
// Vector sweep counter (0x0..0xF) with a pass counter that advances on wrap.
// The vector register doubles as the registered drive into the block under test.
module hwt_bist_vecgen
  import hwt_bist_pkg::*;
#(
  parameter int NUM_PASSES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [VEC_W-1:0] vec,
  output logic             last_vec,
  output logic             last_pass
);

  logic [7:0] pass_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      pass_cnt <= '0;
    end else if (clear) begin
      vec      <= '0;
      pass_cnt <= '0;
    end else if (step) begin
      // 4-bit vector wraps 0xF -> 0x0 on its own; the pass counter follows the wrap
      vec <= vec + 4'd1;
      if (last_vec) pass_cnt <= pass_cnt + 8'd1;
    end
  end

  assign last_vec  = (vec == 4'hF);
  assign last_pass = (pass_cnt == 8'(NUM_PASSES - 1));

endmodule

// File: rtl/hwt_bist_ctrl.sv
// BIST controller: sweeps all 16 input vectors into the function block, compares Y
// with the golden function, counts mismatches (saturating) and captures the first failing vector.
module hwt_bist_ctrl
  import hwt_bist_pkg::*;
#(
  parameter int NUM_PASSES    = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  output logic             dut_d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_count,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid,
  output state_t           dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       SETTLE_END = 4'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [VEC_W-1:0] vec;
  logic             last_vec;
  logic             last_pass;
  logic             gen_clear;
  logic             gen_step;
  logic             mismatch;

  // Handshake: start is a one-cycle request accepted only in IDLE; abort is
  // honoured in every state and takes priority over start; done is a one-cycle
  // completion pulse and pass/fail_count/first_fail_* stay valid until the next accepted start.

  hwt_bist_vecgen #(
    .NUM_PASSES(NUM_PASSES)
  ) u_vecgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (gen_clear),
    .step     (gen_step),
    .vec      (vec),
    .last_vec (last_vec),
    .last_pass(last_pass)
  );

  // The vector goes back to 0 on start, abort and the final sample, so the
  // block inputs read 0 whenever the controller is idle.
  always_comb begin
    gen_clear = 1'b0;
    gen_step  = 1'b0;
    if (abort) begin
      gen_clear = 1'b1;
    end else begin
      case (state)
        IDLE:    gen_clear = start;
        SAMPLE: begin
          if (last_vec && last_pass) gen_clear = 1'b1;
          else                       gen_step  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mismatch = (state == SAMPLE) && (dut_y != golden_y(vec));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_count       <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              fail_count       <= '0;
              first_fail_valid <= 1'b0;
              pass             <= 1'b0;
              busy             <= 1'b1;
              settle_cnt       <= '0;
              state            <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_END) state <= SAMPLE;
            else                          settle_cnt <= settle_cnt + 4'd1;
          end
          SAMPLE: begin
            settle_cnt <= '0;
            if (mismatch) begin
              if (fail_count != CNT_MAX) fail_count <= fail_count + 1'b1;
              if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
              end
            end
            if (last_vec && last_pass) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Include this cycle's compare, which has not reached fail_count yet
              pass  <= (fail_count == '0) && !mismatch;
            end else begin
              state <= SETTLE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign {dut_a, dut_b, dut_c, dut_d} = vec;
  assign dbg_state = state;

endmodule

// File: tb/tb_hwt_bist_ctrl.sv
// Testbench for hwt_bist_ctrl: three instances (defaults, NUM_PASSES=3, CNT_W=2) each
// driven by a selectable model of the function block; results are checked on every done pulse.
module tb_hwt_bist_ctrl;
  import hwt_bist_pkg::*;

  typedef struct packed {
    logic [7:0]  cnt;
    logic [3:0]  ffv;
    logic        ffval;
    logic        pass;
    logic [15:0] lat;
  } exp_t;

  localparam int M_MODE_CLEAN = 0;
  localparam int M_MODE_TIE0  = 1;
  localparam int M_MODE_TIE1  = 2;
  localparam int M_MODE_TROJ  = 3;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  // main instance (defaults)
  logic m_start, m_abort, m_y, m_a, m_b, m_c, m_d, m_busy, m_done, m_pass, m_ffval;
  logic [7:0] m_cnt;
  logic [3:0] m_ffv;
  state_t     m_state;
  int         m_mode, m_t0;
  exp_t       m_q[$];

  // NUM_PASSES = 3 instance
  logic p_start, p_abort, p_y, p_a, p_b, p_c, p_d, p_busy, p_done, p_pass, p_ffval;
  logic [7:0] p_cnt;
  logic [3:0] p_ffv;
  state_t     p_state;
  int         p_mode, p_t0;
  exp_t       p_q[$];

  // CNT_W = 2 instance
  logic w_start, w_abort, w_y, w_a, w_b, w_c, w_d, w_busy, w_done, w_pass, w_ffval;
  logic [1:0] w_cnt;
  logic [3:0] w_ffv;
  state_t     w_state;
  int         w_mode, w_t0;
  exp_t       w_q[$];

  function automatic logic model_y(input int mode, input logic [3:0] v);
    case (mode)
      M_MODE_TIE0: return 1'b0;
      M_MODE_TIE1: return 1'b1;
      M_MODE_TROJ: return (v == 4'hE) ? 1'b1 : golden_y(v);
      default:     return golden_y(v);
    endcase
  endfunction

  assign m_y = model_y(m_mode, {m_a, m_b, m_c, m_d});
  assign p_y = model_y(p_mode, {p_a, p_b, p_c, p_d});
  assign w_y = model_y(w_mode, {w_a, w_b, w_c, w_d});

  hwt_bist_ctrl u_m (
    .clk(clk), .rst_n(rst_n), .start(m_start), .abort(m_abort), .dut_y(m_y),
    .dut_a(m_a), .dut_b(m_b), .dut_c(m_c), .dut_d(m_d), .busy(m_busy), .done(m_done),
    .pass(m_pass), .fail_count(m_cnt), .first_fail_vec(m_ffv),
    .first_fail_valid(m_ffval), .dbg_state(m_state)
  );

  hwt_bist_ctrl #(.NUM_PASSES(3)) u_p (
    .clk(clk), .rst_n(rst_n), .start(p_start), .abort(p_abort), .dut_y(p_y),
    .dut_a(p_a), .dut_b(p_b), .dut_c(p_c), .dut_d(p_d), .busy(p_busy), .done(p_done),
    .pass(p_pass), .fail_count(p_cnt), .first_fail_vec(p_ffv),
    .first_fail_valid(p_ffval), .dbg_state(p_state)
  );

  hwt_bist_ctrl #(.CNT_W(2)) u_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort), .dut_y(w_y),
    .dut_a(w_a), .dut_b(w_b), .dut_c(w_c), .dut_d(w_d), .busy(w_busy), .done(w_done),
    .pass(w_pass), .fail_count(w_cnt), .first_fail_vec(w_ffv),
    .first_fail_valid(w_ffval), .dbg_state(w_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_done(input string pfx, input exp_t e, input logic [7:0] cnt,
                            input logic [3:0] ffv, input logic ffval, input logic pass,
                            input logic busy, input int lat);
    check({pfx, "_fail_count"}, 32'(cnt), 32'(e.cnt));
    check({pfx, "_first_fail_valid"}, 32'(ffval), 32'(e.ffval));
    if (e.ffval) check({pfx, "_first_fail_vec"}, 32'(ffv), 32'(e.ffv));
    check({pfx, "_pass"}, 32'(pass), 32'(e.pass));
    check({pfx, "_busy_at_done"}, 32'(busy), 32'd0);
    check({pfx, "_latency"}, 32'(lat), 32'(e.lat));
  endtask

  // scoreboard monitors: one pop per done pulse
  always @(negedge clk) begin
    if (rst_n && m_done) begin
      if (m_q.size() == 0) check("m_unexpected_done", 32'(m_q.size()), 32'd1);
      else check_done("m", m_q.pop_front(), m_cnt, m_ffv, m_ffval, m_pass, m_busy, cyc - m_t0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && p_done) begin
      if (p_q.size() == 0) check("p_unexpected_done", 32'(p_q.size()), 32'd1);
      else check_done("p", p_q.pop_front(), p_cnt, p_ffv, p_ffval, p_pass, p_busy, cyc - p_t0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_done) begin
      if (w_q.size() == 0) check("w_unexpected_done", 32'(w_q.size()), 32'd1);
      else check_done("w", w_q.pop_front(), {6'd0, w_cnt}, w_ffv, w_ffval, w_pass, w_busy, cyc - w_t0);
    end
  end

  // driver tasks
  task automatic pulse_start(input int which, input bit rec);
    @(negedge clk);
    case (which)
      0: m_start = 1'b1;
      1: p_start = 1'b1;
      default: w_start = 1'b1;
    endcase
    @(negedge clk);
    m_start = 1'b0;
    p_start = 1'b0;
    w_start = 1'b0;
    if (rec) begin
      case (which)
        0: m_t0 = cyc;
        1: p_t0 = cyc;
        default: w_t0 = cyc;
      endcase
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0: return m_q.size();
      1: return p_q.size();
      default: return w_q.size();
    endcase
  endfunction

  task automatic drain(input int which, input int budget);
    int n;
    n = 0;
    while (qsize(which) > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain_%0d_timeout", which), 32'(qsize(which)), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_m(input int d);
    while (cyc - m_t0 < d) @(negedge clk);
  endtask

  initial begin
    logic [15:0] mask;
    rst_n = 1'b0;
    m_start = 0; m_abort = 0; p_start = 0; p_abort = 0; w_start = 0; w_abort = 0;
    m_mode = M_MODE_CLEAN; p_mode = M_MODE_CLEAN; w_mode = M_MODE_CLEAN;
    m_t0 = 0; p_t0 = 0; w_t0 = 0;
    n_checks = 0; n_pass = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_dut_abcd", 32'({m_a, m_b, m_c, m_d}), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_pass", 32'(m_pass), 32'd0);
    check("rst_fail_count", 32'(m_cnt), 32'd0);
    check("rst_first_fail", 32'({m_ffval, m_ffv}), 32'd0);
    check("rst_state", 32'(m_state), 32'(IDLE));
    rst_n = 1'b1;

    // golden truth table: ones at 0x3, 0x7, 0xB, 0xD, 0xF
    mask = 16'hA888;
    for (int i = 0; i < 16; i++) check($sformatf("golden_%0h", i), 32'(golden_y(4'(i))), 32'(mask[i]));

    // clean run, with a second start mid-run that must be ignored
    m_mode = M_MODE_CLEAN;
    m_q.push_back('{cnt: 8'd0, ffv: 4'h0, ffval: 1'b0, pass: 1'b1, lat: 16'd32});
    pulse_start(0, 1'b1);
    check("clean_busy_after_start", 32'(m_busy), 32'd1);
    check("clean_state_after_start", 32'(m_state), 32'(SETTLE));
    check("clean_vec_after_start", 32'({m_a, m_b, m_c, m_d}), 32'h0);
    wait_m(5);
    pulse_start(0, 1'b0);
    wait_m(10);
    check("clean_vec_at_10", 32'({m_a, m_b, m_c, m_d}), 32'h5);
    drain(0, 100);
    check("clean_pass_held", 32'(m_pass), 32'd1);
    check("clean_dut_idle", 32'({m_a, m_b, m_c, m_d}), 32'd0);

    // Y stuck at 0
    m_mode = M_MODE_TIE0;
    m_q.push_back('{cnt: 8'd5, ffv: 4'h3, ffval: 1'b1, pass: 1'b0, lat: 16'd32});
    pulse_start(0, 1'b1);
    check("tie0_pass_cleared", 32'(m_pass), 32'd0);
    drain(0, 100);

    // Y stuck at 1
    m_mode = M_MODE_TIE1;
    m_q.push_back('{cnt: 8'd11, ffv: 4'h0, ffval: 1'b1, pass: 1'b0, lat: 16'd32});
    pulse_start(0, 1'b1);
    drain(0, 100);

    // trojan netlist, three passes
    p_mode = M_MODE_TROJ;
    p_q.push_back('{cnt: 8'd3, ffv: 4'hE, ffval: 1'b1, pass: 1'b0, lat: 16'd96});
    pulse_start(1, 1'b1);
    drain(1, 200);

    // 2-bit counter saturates
    w_mode = M_MODE_TIE1;
    w_q.push_back('{cnt: 8'd3, ffv: 4'h0, ffval: 1'b1, pass: 1'b0, lat: 16'd32});
    pulse_start(2, 1'b1);
    drain(2, 100);

    // abort at cycle 10 of a stuck-at-0 run: vectors 0..4 compared, one mismatch at 0x3
    m_mode = M_MODE_TIE0;
    pulse_start(0, 1'b1);
    wait_m(10);
    m_abort = 1'b1;
    @(negedge clk);
    m_abort = 1'b0;
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_dut_abcd", 32'({m_a, m_b, m_c, m_d}), 32'd0);
    check("abort_state", 32'(m_state), 32'(IDLE));
    check("abort_fail_count_kept", 32'(m_cnt), 32'd1);
    check("abort_first_fail_kept", 32'({m_ffval, m_ffv}), 32'h13);
    check("abort_pass", 32'(m_pass), 32'd0);
    repeat (40) @(negedge clk);

    // start and abort together while idle: abort wins
    m_start = 1'b1;
    m_abort = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    m_abort = 1'b0;
    check("start_abort_busy", 32'(m_busy), 32'd0);
    check("start_abort_state", 32'(m_state), 32'(IDLE));
    repeat (40) @(negedge clk);

    // asynchronous reset mid-run
    m_mode = M_MODE_TIE1;
    pulse_start(0, 1'b1);
    wait_m(7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(m_busy), 32'd0);
    check("arst_dut_abcd", 32'({m_a, m_b, m_c, m_d}), 32'd0);
    check("arst_fail_count", 32'(m_cnt), 32'd0);
    check("arst_first_fail", 32'({m_ffval, m_ffv}), 32'd0);
    check("arst_pass_done", 32'({m_pass, m_done}), 32'd0);
    check("arst_state", 32'(m_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_stays_idle", 32'(m_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
